pipeline_control_unit: RTL and testbench

- Control unit for the 5-stage pipelined CPU (F/D/E/M/WB).
- Decodes opcodeD into the CPU's decode-stage control inputs and holds the architectural NZVC flags register.
- Resolves conditional branches in D and squashes the branch shadow, since the PC only updates from WB. It also implements HALT.
- Sits beside the CPU top: it consumes opcodeD, the E-stage flags and the hazard unit's stallD/flushE, and drives every *D/*E/*M/*WB control input.

---
 rtl/pipeline_control_unit_pkg.sv | 52 +++++
 rtl/pipeline_control_unit_if.sv | 58 +++++
 rtl/pipeline_control_unit_decoder.sv | 70 +++++++
 rtl/pipeline_control_unit.sv | 126 ++++++++++++
 tb/tb_pipeline_control_unit.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_control_unit_pkg.sv
//------------------------------------------------------------------------------
// cpu_control_pkg : opcode/ALU encodings, control FSM states, control bundle
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cpu_control_pkg;

    localparam int OP_BITS = 4;

    localparam logic [OP_BITS-1:0] OP_NOP  = 4'h0;
    localparam logic [OP_BITS-1:0] OP_ADD  = 4'h1;
    localparam logic [OP_BITS-1:0] OP_SUB  = 4'h2;
    localparam logic [OP_BITS-1:0] OP_AND  = 4'h3;
    localparam logic [OP_BITS-1:0] OP_OR   = 4'h4;
    localparam logic [OP_BITS-1:0] OP_ADDI = 4'h5;
    localparam logic [OP_BITS-1:0] OP_SUBI = 4'h6;
    localparam logic [OP_BITS-1:0] OP_CMP  = 4'h7;
    localparam logic [OP_BITS-1:0] OP_LDR  = 4'h8;
    localparam logic [OP_BITS-1:0] OP_STR  = 4'h9;
    localparam logic [OP_BITS-1:0] OP_B    = 4'hA;
    localparam logic [OP_BITS-1:0] OP_BEQ  = 4'hB;
    localparam logic [OP_BITS-1:0] OP_BNE  = 4'hC;
    localparam logic [OP_BITS-1:0] OP_BLT  = 4'hD;
    localparam logic [OP_BITS-1:0] OP_JR   = 4'hE;
    localparam logic [OP_BITS-1:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_PASSB = 3'b100;

    typedef enum logic [1:0] {
        CTRL_RUN    = 2'd0,
        CTRL_SHADOW = 2'd1,
        CTRL_HALT   = 2'd2
    } ctrl_state_e;

    typedef struct packed {
        logic       pcSel;
        logic       pcR1;
        logic       we;
        logic       wdm;
        logic       rsel;
        logic       d2sel;
        logic [2:0] alu;
    } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/pipeline_control_unit_if.sv
//------------------------------------------------------------------------------
// pipeline_control_unit_if : CPU <-> control unit signal bundle
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface pipeline_control_unit_if #(
    parameter int OPCODEWIDTH = 4
`ifdef PIPELINE_CONTROL_PERF_EN
    ,
    parameter int CNTWIDTH    = 32
`endif
);
    logic [OPCODEWIDTH-1:0] opcodeD;
    logic                   stallD;
    logic                   flushE;
    logic                   N;
    logic                   Z;
    logic                   V;
    logic                   C;
    logic                   PCSelectorFD;
    logic                   obtainPCAsR1DD;
    logic                   writeEnableDD;
    logic                   writeDataEnableMD;
    logic                   resultSelectorWBD;
    logic                   data2SelectorED;
    logic [2:0]             aluControlED;
    logic [3:0]             flags;
    logic                   halted;
`ifdef PIPELINE_CONTROL_PERF_EN
    logic [CNTWIDTH-1:0]    issuedCount;
    logic [CNTWIDTH-1:0]    squashCount;
    logic [CNTWIDTH-1:0]    stallCount;
`endif

    modport master (
        output opcodeD, stallD, flushE, N, Z, V, C,
        input  PCSelectorFD, obtainPCAsR1DD, writeEnableDD, writeDataEnableMD,
        input  resultSelectorWBD, data2SelectorED, aluControlED, flags, halted
`ifdef PIPELINE_CONTROL_PERF_EN
        ,
        input  issuedCount, squashCount, stallCount
`endif
    );

    modport slave (
        input  opcodeD, stallD, flushE, N, Z, V, C,
        output PCSelectorFD, obtainPCAsR1DD, writeEnableDD, writeDataEnableMD,
        output resultSelectorWBD, data2SelectorED, aluControlED, flags, halted
`ifdef PIPELINE_CONTROL_PERF_EN
        ,
        output issuedCount, squashCount, stallCount
`endif
    );

endinterface

`default_nettype wire

// File: rtl/pipeline_control_unit_decoder.sv
//------------------------------------------------------------------------------
// control_decoder : combinational opcode + effective NZV -> control bundle
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module control_decoder
    import cpu_control_pkg::*;
#(
    parameter int OPCODEWIDTH = 4
) (
    input  logic [OPCODEWIDTH-1:0] opcode,
    input  logic [2:0]             effNZV,
    output ctrl_t                  ctrl,
    output logic                   isTakenBranch,
    output logic                   isHalt,
    output logic                   isCmp
);

    localparam ctrl_t c_BRANCH = '{pcSel: 1'b1, pcR1: 1'b1, we: 1'b0, wdm: 1'b0,
                                   rsel: 1'b0, d2sel: 1'b1, alu: ALU_ADD};

    logic [OP_BITS-1:0] w_op;
    logic               w_condTaken;

    assign w_op = OP_BITS'(opcode);

    // effNZV = {N, Z, V}
    always_comb begin
        w_condTaken = 1'b0;
        case (w_op)
            OP_BEQ:  w_condTaken = effNZV[1];
            OP_BNE:  w_condTaken = ~effNZV[1];
            OP_BLT:  w_condTaken = effNZV[2] ^ effNZV[0];
            default: w_condTaken = 1'b0;
        endcase
    end

    always_comb begin
        ctrl          = '0;
        isTakenBranch = 1'b0;
        isHalt        = 1'b0;
        isCmp         = 1'b0;
        case (w_op)
            OP_ADD:  begin ctrl.we = 1'b1; ctrl.alu = ALU_ADD; end
            OP_SUB:  begin ctrl.we = 1'b1; ctrl.alu = ALU_SUB; end
            OP_AND:  begin ctrl.we = 1'b1; ctrl.alu = ALU_AND; end
            OP_OR:   begin ctrl.we = 1'b1; ctrl.alu = ALU_OR;  end
            OP_ADDI: begin ctrl.we = 1'b1; ctrl.d2sel = 1'b1; ctrl.alu = ALU_ADD; end
            OP_SUBI: begin ctrl.we = 1'b1; ctrl.d2sel = 1'b1; ctrl.alu = ALU_SUB; end
            OP_CMP:  begin ctrl.alu = ALU_SUB; isCmp = 1'b1; end
            OP_LDR:  begin ctrl.we = 1'b1; ctrl.d2sel = 1'b1; ctrl.rsel = 1'b1; ctrl.alu = ALU_ADD; end
            OP_STR:  begin ctrl.wdm = 1'b1; ctrl.d2sel = 1'b1; ctrl.alu = ALU_ADD; end
            OP_B:    begin ctrl = c_BRANCH; isTakenBranch = 1'b1; end
            OP_BEQ, OP_BNE, OP_BLT: begin
                if (w_condTaken) begin
                    ctrl          = c_BRANCH;
                    isTakenBranch = 1'b1;
                end
            end
            // Register-relative jump: operand 1 stays reg1, target = reg1 + imm
            OP_JR:   begin ctrl.pcSel = 1'b1; ctrl.d2sel = 1'b1; ctrl.alu = ALU_ADD; isTakenBranch = 1'b1; end
            OP_HALT: isHalt = 1'b1;
            default: ctrl = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/pipeline_control_unit.sv
//------------------------------------------------------------------------------
// pipeline_control_unit : decode control, NZVC flags, branch shadow, HALT.
// Optional perf counters under PIPELINE_CONTROL_PERF_EN.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipeline_control_unit
    import cpu_control_pkg::*;
#(
    parameter int OPCODEWIDTH   = 4,
    parameter int BRANCH_SHADOW = 4
`ifdef PIPELINE_CONTROL_PERF_EN
    ,
    parameter int CNTWIDTH      = 32
`endif
) (
    input  logic                 clock,
    input  logic                 reset,
    pipeline_control_unit_if.slave bus
);

    localparam int CNT_W = $clog2(BRANCH_SHADOW + 1);

    ctrl_state_e      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_flags;
    logic             r_cmpE;

    ctrl_t            w_decCtrl;
    ctrl_t            w_ctrl;
    logic             w_isTaken;
    logic             w_isHalt;
    logic             w_isCmp;
    logic [2:0]       w_effNZV;

    // Bypass live ALU flags when the CMP that produces them is in E right now
    assign w_effNZV = r_cmpE ? {bus.N, bus.Z, bus.V} : r_flags[3:1];

    control_decoder #(.OPCODEWIDTH(OPCODEWIDTH)) u_decoder (
        .opcode        (bus.opcodeD),
        .effNZV        (w_effNZV),
        .ctrl          (w_decCtrl),
        .isTakenBranch (w_isTaken),
        .isHalt        (w_isHalt),
        .isCmp         (w_isCmp)
    );

    always_comb begin
        w_ctrl = '0;
        if (reset && r_state == CTRL_RUN)
            w_ctrl = w_decCtrl;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= CTRL_RUN;
            r_cnt   <= '0;
            r_flags <= '0;
            r_cmpE  <= 1'b0;
        end else begin
            if (r_cmpE)
                r_flags <= {bus.N, bus.Z, bus.V, bus.C};
            r_cmpE <= w_isCmp && (r_state == CTRL_RUN) && !bus.stallD && !bus.flushE;
            case (r_state)
                CTRL_RUN: begin
                    if (!bus.stallD) begin
                        if (w_isTaken) begin
                            r_state <= CTRL_SHADOW;
                            r_cnt   <= CNT_W'(BRANCH_SHADOW - 1);
                        end else if (w_isHalt) begin
                            r_state <= CTRL_HALT;
                        end
                    end
                end
                CTRL_SHADOW: begin
                    if (!bus.stallD) begin
                        if (r_cnt == '0)
                            r_state <= CTRL_RUN;
                        else
                            r_cnt <= r_cnt - 1'b1;
                    end
                end
                CTRL_HALT: r_state <= CTRL_HALT;
                default:   r_state <= CTRL_RUN;
            endcase
        end
    end

`ifdef PIPELINE_CONTROL_PERF_EN
    logic [CNTWIDTH-1:0] r_issued;
    logic [CNTWIDTH-1:0] r_squash;
    logic [CNTWIDTH-1:0] r_stall;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_issued <= '0;
            r_squash <= '0;
            r_stall  <= '0;
        end else if (r_state != CTRL_HALT) begin
            if (r_state == CTRL_RUN && !bus.stallD && bus.opcodeD != OPCODEWIDTH'(OP_NOP))
                r_issued <= r_issued + 1'b1;
            if (r_state == CTRL_SHADOW && !bus.stallD)
                r_squash <= r_squash + 1'b1;
            if (bus.stallD)
                r_stall <= r_stall + 1'b1;
        end
    end

    assign bus.issuedCount = r_issued;
    assign bus.squashCount = r_squash;
    assign bus.stallCount  = r_stall;
`endif

    assign bus.PCSelectorFD      = w_ctrl.pcSel;
    assign bus.obtainPCAsR1DD    = w_ctrl.pcR1;
    assign bus.writeEnableDD     = w_ctrl.we;
    assign bus.writeDataEnableMD = w_ctrl.wdm;
    assign bus.resultSelectorWBD = w_ctrl.rsel;
    assign bus.data2SelectorED   = w_ctrl.d2sel;
    assign bus.aluControlED      = w_ctrl.alu;
    assign bus.flags             = r_flags;
    assign bus.halted            = (r_state == CTRL_HALT);

endmodule

`default_nettype wire

// File: tb/tb_pipeline_control_unit.sv
//------------------------------------------------------------------------------
// tb_pipeline_control_unit : scoreboard bench for the pipeline control unit
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipeline_control_unit;

    // {pcsel, pcr1, we, wdm, rsel, d2sel, alu[2:0]}
    localparam logic [8:0] c_NOP = 9'b000000000;
    localparam logic [8:0] c_ADD = 9'b001000000;
    localparam logic [8:0] c_CMP = 9'b000000001;
    localparam logic [8:0] c_BR  = 9'b110001000;
    localparam logic [8:0] c_JR  = 9'b100001000;
    localparam logic [8:0] c_LDR = 9'b001011000;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   nChecks = 0;
    int   nFails  = 0;
    logic [8:0] expQ[$];

    pipeline_control_unit_if #(.OPCODEWIDTH(4)) bus ();

    pipeline_control_unit #(.OPCODEWIDTH(4), .BRANCH_SHADOW(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [8:0] ctrlVec();
        return {bus.PCSelectorFD, bus.obtainPCAsR1DD, bus.writeEnableDD,
                bus.writeDataEnableMD, bus.resultSelectorWBD, bus.data2SelectorED,
                bus.aluControlED};
    endfunction

    task automatic drive(input logic rstN, input logic [3:0] op, input logic st,
                         input logic fl, input logic [3:0] nzvc);
        @(negedge clock);
        reset       = rstN;
        bus.opcodeD = op;
        bus.stallD  = st;
        bus.flushE  = fl;
        {bus.N, bus.Z, bus.V, bus.C} = nzvc;
    endtask

    task automatic test_reset();
        logic [8:0] e;
        logic [8:0] got;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 4'h1, 1'b0, 1'b0, 4'b1111);
            expQ.push_back(c_NOP);
            #1 got = ctrlVec();
            e = expQ.pop_front();
            nChecks++;
            if (got !== e) begin nFails++; $display("FAIL reset_ctrl[%0d] got=%b exp=%b", i, got, e); end
        end
        @(posedge clock); #1;
        nChecks++;
        if (bus.flags !== 4'b0000 || bus.halted !== 1'b0) begin
            nFails++; $display("FAIL reset_state flags=%b halted=%b exp 0000/0", bus.flags, bus.halted);
        end
        drive(1'b1, 4'h1, 1'b0, 1'b0, 4'b0000);
        expQ.push_back(c_ADD);
        #1 got = ctrlVec();
        e = expQ.pop_front();
        nChecks++;
        if (got !== e) begin nFails++; $display("FAIL reset_release_add got=%b exp=%b", got, e); end
    endtask

    task automatic test_cmp_bypass();
        logic [3:0] ops  [7] = '{4'h7, 4'hB, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
        logic [3:0] nzvc [7] = '{4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        logic [8:0] exps [7] = '{c_CMP, c_BR, c_NOP, c_NOP, c_NOP, c_NOP, c_ADD};
        logic [8:0] e;
        logic [8:0] got;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, ops[i], 1'b0, 1'b0, nzvc[i]);
            expQ.push_back(exps[i]);
            #1 got = ctrlVec();
            e = expQ.pop_front();
            nChecks++;
            if (got !== e) begin nFails++; $display("FAIL cmp_beq_slot[%0d] got=%b exp=%b", i, got, e); end
            if (i == 1) begin
                @(posedge clock); #1;
                nChecks++;
                if (bus.flags !== 4'b0100) begin nFails++; $display("FAIL cmp_flags got=%b exp=0100", bus.flags); end
            end
        end
    endtask

    task automatic test_bne_not_taken();
        logic [3:0] ops  [3] = '{4'hC, 4'h1, 4'hD};
        logic [8:0] exps [3] = '{c_NOP, c_ADD, c_NOP};
        logic [8:0] e;
        logic [8:0] got;
        // Stored Z=1, live flags ignored because no CMP is in E; BLT: N^V=0
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ops[i], 1'b0, 1'b0, 4'b1000);
            expQ.push_back(exps[i]);
            #1 got = ctrlVec();
            e = expQ.pop_front();
            nChecks++;
            if (got !== e) begin nFails++; $display("FAIL bne_not_taken[%0d] got=%b exp=%b", i, got, e); end
        end
        drive(1'b1, 4'h1, 1'b0, 1'b0, 4'b0000);
        #1 got = ctrlVec();
        nChecks++;
        if (got !== c_ADD || bus.flags !== 4'b0100) begin
            nFails++; $display("FAIL no_shadow got=%b flags=%b exp=%b/0100", got, bus.flags, c_ADD);
        end
    endtask

    task automatic test_stall_shadow();
        logic [3:0] ops  [8] = '{4'hA, 4'h1, 4'hB, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
        logic       sts  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [8:0] exps [8] = '{c_BR, c_NOP, c_NOP, c_NOP, c_NOP, c_NOP, c_NOP, c_ADD};
        logic [8:0] e;
        logic [8:0] got;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, ops[i], sts[i], 1'b0, 4'b0000);
            expQ.push_back(exps[i]);
            #1 got = ctrlVec();
            e = expQ.pop_front();
            nChecks++;
            if (got !== e) begin nFails++; $display("FAIL stall_shadow[%0d] got=%b exp=%b", i, got, e); end
        end
    endtask

    task automatic test_back_to_back();
        // Stalled RUN still decodes; stalled JR creates no shadow; flushed CMP leaves flags alone
        logic [3:0] ops  [6] = '{4'hE, 4'h8, 4'h7, 4'h1, 4'h7, 4'h1};
        logic       sts  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       fls  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [8:0] exps [6] = '{c_JR, c_LDR, c_CMP, c_ADD, c_CMP, c_ADD};
        logic [8:0] e;
        logic [8:0] got;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, ops[i], sts[i], fls[i], 4'b1011);
            expQ.push_back(exps[i]);
            #1 got = ctrlVec();
            e = expQ.pop_front();
            nChecks++;
            if (got !== e) begin nFails++; $display("FAIL b2b[%0d] got=%b exp=%b", i, got, e); end
        end
        @(posedge clock); #1;
        nChecks++;
        if (bus.flags !== 4'b0100) begin nFails++; $display("FAIL flushed_cmp_flags got=%b exp=0100", bus.flags); end
    endtask

    task automatic test_halt();
        logic [3:0] ops  [4] = '{4'hF, 4'h1, 4'hA, 4'h8};
        logic [8:0] e;
        logic [8:0] got;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ops[i], 1'b0, 1'b0, 4'b0000);
            expQ.push_back(c_NOP);
            #1 got = ctrlVec();
            e = expQ.pop_front();
            nChecks++;
            if (got !== e) begin nFails++; $display("FAIL halt_ctrl[%0d] got=%b exp=%b", i, got, e); end
            if (i > 0) begin
                nChecks++;
                if (bus.halted !== 1'b1) begin nFails++; $display("FAIL halted[%0d] got=%b exp=1", i, bus.halted); end
            end
        end
        drive(1'b0, 4'h1, 1'b0, 1'b0, 4'b0000);
        @(posedge clock); #1;
        nChecks++;
        if (bus.halted !== 1'b0 || bus.flags !== 4'b0000) begin
            nFails++; $display("FAIL halt_reset halted=%b flags=%b exp 0/0000", bus.halted, bus.flags);
        end
        drive(1'b1, 4'h1, 1'b0, 1'b0, 4'b0000);
        expQ.push_back(c_ADD);
        #1 got = ctrlVec();
        e = expQ.pop_front();
        nChecks++;
        if (got !== e) begin nFails++; $display("FAIL halt_exit_add got=%b exp=%b", got, e); end
    endtask

`ifdef PIPELINE_CONTROL_PERF_EN
    task automatic test_perf();
        logic [3:0] ops [7] = '{4'h1, 4'hA, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0};
        logic       sts [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        drive(1'b0, 4'h0, 1'b0, 1'b0, 4'b0000);
        for (int i = 0; i < 7; i++)
            drive(1'b1, ops[i], sts[i], 1'b0, 4'b0000);
        @(posedge clock); #1;
        nChecks++;
        if (bus.issuedCount !== 32'd2 || bus.squashCount !== 32'd4 || bus.stallCount !== 32'd1) begin
            nFails++;
            $display("FAIL perf issued=%0d squash=%0d stall=%0d exp 2/4/1",
                     bus.issuedCount, bus.squashCount, bus.stallCount);
        end
    endtask
`endif

    initial begin
        bus.opcodeD = 4'h1;
        bus.stallD  = 1'b0;
        bus.flushE  = 1'b0;
        {bus.N, bus.Z, bus.V, bus.C} = 4'b0000;
        test_reset();
        test_cmp_bypass();
        test_bne_not_taken();
        test_stall_shadow();
        test_back_to_back();
        test_halt();
`ifdef PIPELINE_CONTROL_PERF_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

`default_nettype wire
